// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word fetches over a
// valid/ready channel and buffers returned words in a small FIFO for decode.
module ifetch_unit #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [AW-1:0] inst_pc,
    output logic [DW-1:0] inst,
    output logic [6:0]    opcode,
    output logic [2:0]    func3,
    output logic [6:0]    func7,
    output logic          fetch_misalign
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] rsp_pc;
    logic [DW-1:0] fifo_inst [DEPTH];
    logic [AW-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          misalign_q;

    logic [CW:0]   in_flight;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Buffered plus in-flight words are capped at DEPTH, so a push always has room.
    assign in_flight      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !misalign_q && (in_flight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc   <= redirect_pc;
                rsp_pc     <= redirect_pc;
                drop_cnt   <= outstanding_next;
                misalign_q <= (redirect_pc[1:0] != 2'b00);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + AW'(4);
                if (push)
                    rsp_pc <= rsp_pc + AW'(4);
                if (imem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr] <= imem_rsp_data;
                fifo_pc[wr_ptr]   <= rsp_pc;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Head is read straight from storage; a pushed word is visible the cycle after.
    assign inst_valid     = (count != '0);
    assign inst           = inst_valid ? fifo_inst[rd_ptr] : '0;
    assign inst_pc        = inst_valid ? fifo_pc[rd_ptr]   : '0;
    assign opcode         = inst[6:0];
    assign func3          = inst[14:12];
    assign func7          = inst[31:25];
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: queue-based instruction memory with optional
// response hold, a delivery monitor, and hand-computed expectations.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fetch_misalign;

    int n_chk  = 0;
    int n_fail = 0;

    logic        rsp_hold = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    int          fire_cnt = 0;
    int          base_f;
    int          base_g;

    ifetch_unit #(.AW(32), .DW(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst(inst),
        .opcode(opcode), .func3(func3), .func7(func7),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    // Address-dependent word; word(0) = 0x00500093 (addi x1,x0,5).
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 20);
    endfunction

    // Memory: one-cycle latency, in order, responses can be held back.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
                fire_cnt++;
            end
            if (!rsp_hold && pend.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= word(pend.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            got_pc.push_back(inst_pc);
            got_inst.push_back(inst);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got_pc.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wait_got", 32'(got_pc.size() >= n), 32'd1);
    endtask

    initial begin
        // Reset values
        cyc(1);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);

        // Stream from RESET_PC
        base_g = got_pc.size();
        rst = 1'b0;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        wait_got(base_g + 4);
        for (int i = 0; i < 4; i++) begin
            check("stream_pc", got_pc[base_g+i], 32'(4*i));
            check("stream_inst", got_inst[base_g+i], word(32'(4*i)));
        end

        // Backpressure: at most two fetches, head stable
        inst_ready = 1'b0;
        do_reset();
        base_f = fire_cnt;
        cyc(8);
        check("bp_fires", 32'(fire_cnt - base_f), 32'd2);
        check("bp_inst_valid", 32'(inst_valid), 32'd1);
        check("bp_inst_pc", inst_pc, 32'h0);
        check("bp_inst", inst, 32'h0050_0093);
        check("bp_opcode", 32'(opcode), 32'h13);
        check("bp_func3", 32'(func3), 32'h0);
        check("bp_func7", 32'(func7), 32'h0);
        cyc(3);
        check("bp_stable_pc", inst_pc, 32'h0);
        check("bp_no_req", 32'(imem_req_valid), 32'd0);
        base_g = got_pc.size();
        inst_ready = 1'b1;
        wait_got(base_g + 3);
        for (int i = 0; i < 3; i++) begin
            check("bp_order_pc", got_pc[base_g+i], 32'(4*i));
            check("bp_order_inst", got_inst[base_g+i], word(32'(4*i)));
        end

        // Redirect with two responses outstanding
        rsp_hold = 1'b1;
        do_reset();
        base_f = fire_cnt;
        cyc(4);
        check("rd2_fires", 32'(fire_cnt - base_f), 32'd2);
        base_g = got_pc.size();
        redirect(32'h100);
        check("rd2_inst_valid", 32'(inst_valid), 32'd0);
        rsp_hold = 1'b0;
        wait_got(base_g + 2);
        check("rd2_pc0", got_pc[base_g], 32'h100);
        check("rd2_inst0", got_inst[base_g], 32'h1050_0093);
        check("rd2_pc1", got_pc[base_g+1], 32'h104);

        // Redirect coincident with request fire and response
        rst = 1'b1;
        cyc(2);
        base_g = got_pc.size();
        rst = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("co_rsp_valid", 32'(imem_rsp_valid), 32'd1);
        check("co_req_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("co_inst_valid", 32'(inst_valid), 32'd0);
        wait_got(base_g + 2);
        check("co_pc0", got_pc[base_g], 32'h100);
        check("co_inst0", got_inst[base_g], word(32'h100));
        check("co_pc1", got_pc[base_g+1], 32'h104);
        check("co_inst1", got_inst[base_g+1], word(32'h104));

        // Misaligned redirect halts fetch, aligned redirect resumes
        redirect(32'h102);
        base_f = fire_cnt;
        cyc(6);
        check("mis_flag", 32'(fetch_misalign), 32'd1);
        check("mis_req_valid", 32'(imem_req_valid), 32'd0);
        check("mis_inst_valid", 32'(inst_valid), 32'd0);
        check("mis_fires", 32'(fire_cnt - base_f), 32'd0);
        base_g = got_pc.size();
        redirect(32'h200);
        check("mis_clear", 32'(fetch_misalign), 32'd0);
        check("mis_resume_valid", 32'(imem_req_valid), 32'd1);
        check("mis_resume_addr", imem_req_addr, 32'h200);
        wait_got(base_g + 1);
        check("mis_pc0", got_pc[base_g], 32'h200);
        check("mis_inst0", got_inst[base_g], 32'h2050_0093);

        // Asynchronous reset with a full FIFO
        inst_ready = 1'b0;
        cyc(6);
        check("ar_full_valid", 32'(inst_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_inst_valid", 32'(inst_valid), 32'd0);
        check("ar_req_valid", 32'(imem_req_valid), 32'd0);
        check("ar_inst", inst, 32'h0);
        check("ar_inst_pc", inst_pc, 32'h0);
        cyc(2);
        inst_ready = 1'b1;
        base_g = got_pc.size();
        rst = 1'b0;
        #1;
        check("ar_restart_addr", imem_req_addr, 32'h0);
        wait_got(base_g + 1);
        check("ar_restart_pc", got_pc[base_g], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
